clk_div_prog: RTL
=================

# clk_div_prog

Runtime-programmable clock divider producing a divided clock-enable waveform with programmable period and high time, plus a single-cycle period-start tick. It is the parametrised successor to the fixed divide-by-1000 divider and powers up reproducing its waveform: period 1000, high 500. Reconfiguration is glitch-free, because new settings take effect only at a period boundary. It sits between the board clock and slow peripherals such as LED scanners, debouncers and UART baud generation.

## Interface

- WIDTH, 16, width of divisor, high-time and counter fields.
- DEFAULT_DIV, 1000, period in clk cycles after reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1.
- DEFAULT_HIGH, 500, high time in clk cycles after reset; must satisfy 1 ≤ DEFAULT_HIGH < DEFAULT_DIV.

Ports:

- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run request.
- cfg_valid  in  1  config offer.
- cfg_div  in  WIDTH  requested period N.
- cfg_high  in  WIDTH  requested high time H.
- cfg_ready  out  1  config slot free (no pending config).
- cfg_err  out  1  one-cycle pulse: offered config was illegal and was dropped.
- clk_out  out  1  divided waveform, registered.
- tick  out  1  one-cycle pulse at each period start, registered.
- running  out  1  FSM in RUN.
- active_div  out  WIDTH  period N currently in use.

## Operation

- Reset values:
  - clk_out=0, tick=0, running=0, cfg_err=0, cfg_ready=1.
  - cnt=0, pending=0.
  - active N=DEFAULT_DIV, active H=DEFAULT_HIGH, so active_div=DEFAULT_DIV.
- FSM states are IDLE and RUN.
- IDLE:
  - clk_out=0 and cnt=0.
  - On an edge with en=1: apply the pending config if any, cnt←0, clk_out←1, tick←1, go to RUN.
- RUN, cnt < N−1: cnt←cnt+1, clk_out←(cnt+1 < H), tick←0.
- RUN, cnt = N−1 (period end):
  - If en=1: cnt←0, apply the pending config if any, clk_out←1, tick←1, stay in RUN.
  - If en=0: go to IDLE, clk_out←0, tick←0.
  - Deasserting en never truncates a period.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready.
  - Legal config: 2 ≤ cfg_div and 1 ≤ cfg_high < cfg_div. A legal config is captured into shadow registers and pending←1.
  - An illegal config is dropped, cfg_err pulses for 1 cycle, and pending is unchanged.
  - cfg_ready = ~pending.
- Applying a config: active N/H←shadow and pending←0, in the same edge as the period start. cfg_ready is high from the next cycle.
- Simultaneous events:
  - A config accepted on a period-start edge is not applied at that edge; it becomes pending and applies at the following boundary.
  - en falling on the period-end edge: the FSM goes to IDLE and the pending config is kept until the next start.
- Arithmetic:
  - Unsigned WIDTH-bit.
  - The comparison cnt+1 < H uses WIDTH+1 bits, so there is no wrap.
  - cnt never exceeds N−1.
- Reset mid-operation: asynchronous return to all reset values. A pending config is lost and the active config reverts to the defaults.

## Timing

- Start latency: tick and clk_out rise 1 cycle after the edge that samples en=1 in IDLE.
- Period is exactly N cycles: clk_out is high for H cycles, then low for N−H cycles.
- tick is high for the first cycle of each period, coincident with the rising edge of clk_out.
- Config latency: from acceptance to taking effect is at most 2N cycles while running, or the next start if idle.
- cfg_err appears 1 cycle after the rejected offer.
- Outputs are registered; there is no combinational path from inputs to outputs except cfg_ready, which depends only on internal state.

## Structure

- Shared package clk_div_pkg holds:
  - the default-period constants (DIV1000 = 1000, HALF1000 = 500);
  - the state enum (IDLE, RUN);
  - the legality-check function cfg_legal(div, high).
- One sub-module is natural: clk_div_cfg_shadow, containing the handshake, legality check, shadow registers, pending flag and cfg_err.
- The counter/FSM stays in the top module.
- Parameter legality is checked at elaboration; an illegal default is a fatal error.

## Test plan

- Reset, then en=1 held, using the defaults: clk_out is high 500 / low 500 cycles, tick every 1000 cycles, first tick 1 cycle after en is sampled, active_div=1000.
- Load N=5, H=2 while running at 1000: applied at the next period start after acceptance. Afterwards clk_out reads 11000 repeating, and tick pulses every 5 cycles.
- Odd and extreme settings: N=2, H=1 gives 1010…; N=3, H=2 gives 110 repeating. A configuration with H=N−1 has exactly one low cycle per period.
- Illegal offers N=1, H=0, and N=4, H=4: each gives a single-cycle cfg_err, cfg_ready stays 1, and the waveform is unchanged.
- en dropped mid-period with N=8, H=3: the period completes all 8 cycles, then clk_out=0 and running=0. Re-asserting en gives a tick 1 cycle after en is sampled.
- Reset asserted mid-period with a config pending: outputs are 0 immediately (asynchronously), cfg_ready=1, and after release active_div=1000.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants, FSM states and config legality check for clk_div_prog
package clk_div_pkg;
    localparam int unsigned DIV1000  = 1000;
    localparam int unsigned HALF1000 = 500;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
    function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
        return div >= 32'd2 && high >= 32'd1 && high < div;
    endfunction
endpackage

// File: rtl/clk_div_cfg_shadow.sv
// clk_div_cfg_shadow: config handshake, legality check, shadow registers and pending flag
module clk_div_cfg_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             apply,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             pending,
    output logic [WIDTH-1:0] shadow_div,
    output logic [WIDTH-1:0] shadow_high
);
    logic accept;
    logic legal;
    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & cfg_ready;
    assign legal     = cfg_legal(32'(cfg_div), 32'(cfg_high));
    // accept needs pending=0 and apply needs pending=1, so they never coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending     <= 1'b0;
            cfg_err     <= 1'b0;
            shadow_div  <= '0;
            shadow_high <= '0;
        end else begin
            cfg_err <= accept & ~legal;
            if (accept & legal) begin
                pending     <= 1'b1;
                shadow_div  <= cfg_div;
                shadow_high <= cfg_high;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider with period-start tick
// and glitch-free reconfiguration at period boundaries.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned DEFAULT_DIV  = DIV1000,
    parameter int unsigned DEFAULT_HIGH = HALF1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] active_div
);
    generate
        if (DEFAULT_DIV < 2 || 64'(DEFAULT_DIV) >= (64'd1 << WIDTH) ||
            DEFAULT_HIGH < 1 || DEFAULT_HIGH >= DEFAULT_DIV) begin : g_bad_defaults
            $fatal(1, "clk_div_prog: illegal DEFAULT_DIV/DEFAULT_HIGH");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_high;
    logic [WIDTH-1:0] shadow_div;
    logic [WIDTH-1:0] shadow_high;
    logic [WIDTH:0]   cnt_inc;
    logic             pending;
    logic             last;
    logic             start;

    assign running = state == RUN;
    assign cnt_inc = (WIDTH+1)'(cnt) + (WIDTH+1)'(1);
    assign last    = running & (cnt == active_div - WIDTH'(1));
    assign start   = en & (~running | last);

    clk_div_cfg_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .apply      (start & pending),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .pending    (pending),
        .shadow_div (shadow_div),
        .shadow_high(shadow_high)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            active_div  <= WIDTH'(DEFAULT_DIV);
            active_high <= WIDTH'(DEFAULT_HIGH);
        end else if (start) begin
            state   <= RUN;
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
            if (pending) begin
                active_div  <= shadow_div;
                active_high <= shadow_high;
            end
        end else if (running & ~last) begin
            cnt     <= cnt_inc[WIDTH-1:0];
            clk_out <= cnt_inc < {1'b0, active_high};
            tick    <= 1'b0;
        end else begin
            // idle, or period end with en low: the period is never truncated
            state   <= IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end
    end
endmodule
